core_fetch: RTL

- Instruction fetch stage directly upstream of core_decode.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Presents a registered INST/INST_PC/INST_VALID triple to decode, with stall back-pressure and branch/jump redirect.
- A one-entry skid buffer absorbs the in-flight memory word when decode stalls, so no fetch is lost or duplicated.

---
 rtl/core_fetch.sv | 84 ++++++++
 1 files changed

// File: rtl/core_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory and hands a registered INST/INST_PC/INST_VALID triple to decode.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [31:0]       REDIRECT_PC,
  output logic              IMEM_EN,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic [31:0]       IMEM_DATA,
  output logic [31:0]       INST,
  output logic [31:0]       INST_PC,
  output logic              INST_VALID
);

  logic [31:0] fetch_pc;
  logic        req_v;
  logic [31:0] req_pc;
  logic        skid_v;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        issue;
  logic        unused_bits;

  assign issue     = !RST && !STALL && !REDIRECT;
  assign IMEM_EN   = issue;
  assign IMEM_ADDR = fetch_pc[ADDR_W+1:2];

  // Byte-offset bits and PC bits above the memory range are intentionally dropped.
  assign unused_bits = ^{REDIRECT_PC[1:0], fetch_pc};

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc   <= RESET_PC;
      req_v      <= 1'b0;
      req_pc     <= 32'h0;
      skid_v     <= 1'b0;
      skid_inst  <= NOP_INST;
      skid_pc    <= 32'h0;
      INST_VALID <= 1'b0;
      INST       <= NOP_INST;
      INST_PC    <= 32'h0;
    end else if (REDIRECT) begin
      // Flush everything in flight, including a word returning this cycle.
      fetch_pc   <= {REDIRECT_PC[31:2], 2'b00};
      req_v      <= 1'b0;
      skid_v     <= 1'b0;
      INST_VALID <= 1'b0;
      INST       <= NOP_INST;
    end else begin
      req_v  <= issue;
      req_pc <= fetch_pc;
      if (issue)
        fetch_pc <= fetch_pc + 32'd4;

      if (!STALL) begin
        if (skid_v) begin
          INST       <= skid_inst;
          INST_PC    <= skid_pc;
          INST_VALID <= 1'b1;
          skid_v     <= 1'b0;
        end else if (req_v) begin
          INST       <= IMEM_DATA;
          INST_PC    <= req_pc;
          INST_VALID <= 1'b1;
        end else begin
          INST_VALID <= 1'b0;
          INST       <= NOP_INST;
        end
      end else if (req_v) begin
        // No issue happens while stalled, so at most this one word needs parking.
        skid_inst <= IMEM_DATA;
        skid_pc   <= req_pc;
        skid_v    <= 1'b1;
      end
    end
  end

endmodule
